// File: rtl/div_sequencer.sv
// Multi-cycle restoring divide controller for the execute stage: sequences
// WIDTH iterations, stalls F/D/E while busy and presents HI/LO when it releases.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_startE,
    input  logic             div_signedE,
    input  logic [WIDTH-1:0] opaE,
    input  logic [WIDTH-1:0] opbE,
    input  logic             flushE,
    output logic             stall_divE,
    output logic             div_readyE,
    output logic [WIDTH-1:0] div_hiE,
    output logic [WIDTH-1:0] div_loE
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, dvsr, opa_raw;
    logic [WIDTH-1:0] hi_q, lo_q, fin_hi, fin_lo;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             sign_q, sign_r, divzero;
    logic [WIDTH:0]   trial;
    logic             start_ok;

    assign start_ok = div_startE & ~flushE;
    assign mag_a    = (div_signedE & opaE[WIDTH-1]) ? -opaE : opaE;
    assign mag_b    = (div_signedE & opbE[WIDTH-1]) ? -opbE : opbE;

    // One restoring step: shift {rem,quo} left, trial-subtract on WIDTH+1 bits.
    assign trial = {rem, quo[WIDTH-1]} - {1'b0, dvsr};

    assign fin_lo = divzero ? '1      : (sign_q ? -quo : quo);
    assign fin_hi = divzero ? opa_raw : (sign_r ? -rem : rem);

    // The consumer samples alongside div_readyE, so DONE bypasses the hold regs.
    assign div_loE = (state == DONE) ? fin_lo : lo_q;
    assign div_hiE = (state == DONE) ? fin_hi : hi_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        stall_divE = 1'b0;
        div_readyE = 1'b0;
        unique case (state)
            IDLE: begin
                stall_divE = start_ok;
                if (start_ok) state_nxt = CALC;
            end
            CALC: begin
                stall_divE = ~flushE;
                if (flushE)                     state_nxt = IDLE;
                else if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
            end
            DONE: begin
                // Never restarts from here, even with div_startE still high.
                div_readyE = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            dvsr    <= '0;
            opa_raw <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            divzero <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            unique case (state)
                IDLE: if (start_ok) begin
                    cnt     <= '0;
                    rem     <= '0;
                    quo     <= mag_a;
                    dvsr    <= mag_b;
                    opa_raw <= opaE;
                    sign_q  <= div_signedE & (opaE[WIDTH-1] ^ opbE[WIDTH-1]);
                    sign_r  <= div_signedE & opaE[WIDTH-1];
                    divzero <= (opbE == '0);
                end
                CALC: if (!flushE) begin
                    rem <= trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                    cnt <= cnt + CW'(1);
                end
                DONE: begin
                    hi_q <= fin_hi;
                    lo_q <= fin_lo;
                end
                default: ;
            endcase
        end
    end

endmodule
